rbm_vote_controller: RTL and testbench
======================================

Name: rbm_vote_controller

Overview:
Iteration controller and vote accumulator for a stochastic RBM classifier chain. It repeatedly resets the downstream layer pipeline and collects one binary output sample per iteration. Each sample bit adds to a saturating per-class counter. The run ends when the iteration budget is reached, a confidence margin is met (early stop), or the layer pipeline stalls (timeout). The block then presents per-class counts and the argmax winner.

Parameters:
output_dim, 10, number of classes (sample width, counter count)
count_width, 12, width of each class vote counter
iter_width, 10, width of iteration limit/counter
timeout_width, 16, width of the per-iteration wait-cycle counter
timeout_cycles, 50000, maximum cycles in WAIT before abort (must be < 2^timeout_width)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  one-cycle request to begin a run; honoured in IDLE or DONE only
iter_limit  input  iter_width  iterations per run; sampled on accepted start
margin  input  count_width  early-stop margin (top minus runner-up); 0 disables; sampled on accepted start
layer_reset  output  1  reset to downstream RBM layers
layer_finish  input  1  downstream sample valid; observed only in WAIT
sample  input  output_dim  one-bit-per-class sample, valid with layer_finish
counts  output  output_dim*count_width  class counters, class i at bits [i*count_width +: count_width]
winner  output  clog2(output_dim)  index of the highest count
iter_count  output  iter_width  completed iterations in the current run
busy  output  1  high in RESET_LAYER, WAIT, EVAL
finish  output  1  high in DONE
early_stop  output  1  run ended on margin; valid while finish
timeout  output  1  run ended on WAIT timeout; valid while finish

Behaviour:
- Reset values: state IDLE; counts=0, winner=0, iter_count=0, busy=0, finish=0, early_stop=0, timeout=0, layer_reset=1. Reset overrides every other input in the same cycle, including mid-run.
- layer_reset = 1 in every state except WAIT. The downstream chain is held in reset while idle, done, or between iterations.
- IDLE/DONE + start:
  - Clear counts, iter_count, winner, and flags; latch iter_limit and margin.
  - If the latched limit is 0, go to DONE next cycle with all counts 0 and winner 0. layer_reset does not go low.
  - Otherwise go to RESET_LAYER.
- RESET_LAYER: exactly one cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - On layer_finish=1: for each i with sample[i]=1, counts[i] += 1, saturating at 2^count_width-1. iter_count += 1. Go to EVAL.
  - Otherwise, if the wait counter reaches timeout_cycles, go to DONE with timeout=1. Counts stay unchanged.
  - layer_finish takes priority over timeout in the same cycle.
- EVAL: one cycle, computed on the registered counts.
  - winner = index of the maximum count; ties resolve to the lowest index. runner-up = maximum over the remaining classes.
  - Register winner.
  - If iter_count == latched limit, go to DONE.
  - Else if margin != 0 and (top - runner-up) >= margin, go to DONE with early_stop=1.
  - Otherwise go to RESET_LAYER.
  - Limit check takes priority, so early_stop=0 when both conditions hold.
- Latency per iteration: 3 cycles plus downstream compute (RESET_LAYER, WAIT ≥1, EVAL).
- DONE: finish=1; counts, winner, iter_count, and flags are held until start or reset. start in DONE behaves as in IDLE; finish drops the next cycle.
- start while busy is ignored. layer_finish outside WAIT is ignored.
- All comparisons are unsigned. Subtraction is done at count_width; the result cannot underflow because top ≥ runner-up.
- output_dim=1: runner-up is 0, so the margin compares against the top count alone.

Test Plan:
1. iter_limit=5, margin=0, downstream returns sample=10'b0000001000 each time → finish after 5 iterations, counts[3]=5, others 0, winner=3, early_stop=0, timeout=0.
2. iter_limit=100, margin=4, sample constant 10'b0000000010 → EVAL after 4th iteration sees 4-0≥4; finish with iter_count=4, winner=1, early_stop=1.
3. Tie case: iter_limit=2, samples 10'b0000100100 then 10'b0000100100 → counts[2]=counts[5]=2, winner=2.
4. count_width=3, iter_limit=10, sample all-ones → every count saturates at 7; iter_count=10; no wrap to 0.
5. iter_limit=3, downstream never asserts layer_finish, timeout_cycles=20 → finish 20 cycles after entering WAIT, timeout=1, iter_count=0, layer_reset back to 1.
6. Assert reset during WAIT of iteration 2 → next cycle IDLE, counts=0, finish=0, layer_reset=1. Also: iter_limit=0 start → finish after one cycle, layer_reset never low. Also: start pulse while busy → run unaffected.

Source files
------------

// File: rtl/rbm_vote_controller.sv
// Iteration controller and saturating vote accumulator for a stochastic RBM classifier chain.
// Each iteration pulses the downstream layers out of reset, collects one sample, and updates per-class votes.
module rbm_vote_controller #(
    parameter int output_dim     = 10,
    parameter int count_width    = 12,
    parameter int iter_width     = 10,
    parameter int timeout_width  = 16,
    parameter int timeout_cycles = 50000,
    localparam int WIN_W = (output_dim > 1) ? $clog2(output_dim) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [iter_width-1:0]             iter_limit,
    input  logic [count_width-1:0]            margin,
    output logic                              layer_reset,
    input  logic                              layer_finish,
    input  logic [output_dim-1:0]             sample,
    output logic [output_dim*count_width-1:0] counts,
    output logic [WIN_W-1:0]                  winner,
    output logic [iter_width-1:0]             iter_count,
    output logic                              busy,
    output logic                              finish,
    output logic                              early_stop,
    output logic                              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_LAYER,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [timeout_width-1:0] WAIT_LAST = timeout_width'(timeout_cycles - 1);
    localparam logic [count_width-1:0]   COUNT_MAX = {count_width{1'b1}};

    state_t                   state_q, state_d;
    logic [iter_width-1:0]    limit_q, limit_d;
    logic [count_width-1:0]   margin_q, margin_d;
    logic [iter_width-1:0]    iter_q, iter_d;
    logic [WIN_W-1:0]         winner_q, winner_d;
    logic [timeout_width-1:0] wait_cnt_q, wait_cnt_d;
    logic                     early_q, early_d;
    logic                     timeout_q, timeout_d;
    logic                     clear_counts;
    logic                     add_sample;

    logic [WIN_W-1:0]         top_idx;
    logic [count_width-1:0]   top_val;
    logic [count_width-1:0]   ru_val;

    // One saturating vote counter per class.
    genvar gi;
    generate
        for (gi = 0; gi < output_dim; gi++) begin : g_class
            logic [count_width-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_counts) begin
                    cnt_d = '0;
                end else if (add_sample && sample[gi] && (cnt_q != COUNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign counts[gi*count_width +: count_width] = cnt_q;
        end
    endgenerate

    // Argmax with lowest-index tie break, then the best of the remaining classes.
    always_comb begin
        top_idx = '0;
        top_val = counts[0 +: count_width];
        for (int i = 1; i < output_dim; i++) begin
            if (counts[i*count_width +: count_width] > top_val) begin
                top_val = counts[i*count_width +: count_width];
                top_idx = WIN_W'(i);
            end
        end
        ru_val = '0;
        for (int i = 0; i < output_dim; i++) begin
            if ((WIN_W'(i) != top_idx) && (counts[i*count_width +: count_width] > ru_val)) begin
                ru_val = counts[i*count_width +: count_width];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        margin_d     = margin_q;
        iter_d       = iter_q;
        winner_d     = winner_q;
        wait_cnt_d   = wait_cnt_q;
        early_d      = early_q;
        timeout_d    = timeout_q;
        clear_counts = 1'b0;
        add_sample   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clear_counts = 1'b1;
                    iter_d       = '0;
                    winner_d     = '0;
                    early_d      = 1'b0;
                    timeout_d    = 1'b0;
                    limit_d      = iter_limit;
                    margin_d     = margin;
                    state_d      = (iter_limit == '0) ? S_DONE : S_RESET_LAYER;
                end
            end
            S_RESET_LAYER: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (layer_finish) begin
                    add_sample = 1'b1;
                    iter_d     = iter_q + 1'b1;
                    state_d    = S_EVAL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_EVAL: begin
                winner_d = top_idx;
                if (iter_q == limit_q) begin
                    state_d = S_DONE;
                end else if ((margin_q != '0) && ((top_val - ru_val) >= margin_q)) begin
                    early_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RESET_LAYER;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            limit_q    <= '0;
            margin_q   <= '0;
            iter_q     <= '0;
            winner_q   <= '0;
            wait_cnt_q <= '0;
            early_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            margin_q   <= margin_d;
            iter_q     <= iter_d;
            winner_q   <= winner_d;
            wait_cnt_q <= wait_cnt_d;
            early_q    <= early_d;
            timeout_q  <= timeout_d;
        end
    end

    assign layer_reset = (state_q != S_WAIT);
    assign busy        = (state_q == S_RESET_LAYER) || (state_q == S_WAIT) || (state_q == S_EVAL);
    assign finish      = (state_q == S_DONE);
    assign winner      = winner_q;
    assign iter_count  = iter_q;
    assign early_stop  = early_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Directed bench for rbm_vote_controller: a reference vote model fills a scoreboard at each start,
// and results are popped and checked when the controller raises finish.
module tb_rbm_vote_controller;

    localparam int OD  = 10;
    localparam int CW  = 3;
    localparam int IW  = 10;
    localparam int TW  = 16;
    localparam int TOC = 20;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [IW-1:0]   iter_limit;
    logic [CW-1:0]   margin;
    logic            layer_reset;
    logic            layer_finish;
    logic [OD-1:0]   sample;
    logic [OD*CW-1:0] counts;
    logic [3:0]      winner;
    logic [IW-1:0]   iter_count;
    logic            busy;
    logic            finish;
    logic            early_stop;
    logic            timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [OD*CW-1:0] counts;
        logic [3:0]       winner;
        logic [IW-1:0]    iter;
        logic             early;
        logic             tmo;
    } exp_t;

    exp_t sb[$];

    rbm_vote_controller #(
        .output_dim(OD), .count_width(CW), .iter_width(IW),
        .timeout_width(TW), .timeout_cycles(TOC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .iter_limit(iter_limit),
        .margin(margin), .layer_reset(layer_reset), .layer_finish(layer_finish),
        .sample(sample), .counts(counts), .winner(winner), .iter_count(iter_count),
        .busy(busy), .finish(finish), .early_stop(early_stop), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: odd iterations see s0, even iterations see s1.
    function automatic exp_t model(input int limit, input int marg,
                                   input logic [OD-1:0] s0, input logic [OD-1:0] s1,
                                   input bit stall);
        int c[OD];
        int top, ti, ru;
        logic [OD-1:0] s;
        exp_t e;
        e = '0;
        for (int i = 0; i < OD; i++) c[i] = 0;
        if (limit == 0) return e;
        if (stall) begin
            e.tmo = 1'b1;
            return e;
        end
        for (int k = 1; k <= limit; k++) begin
            s = (k % 2 == 1) ? s0 : s1;
            for (int i = 0; i < OD; i++)
                if (s[i] && c[i] < (1 << CW) - 1) c[i]++;
            top = -1; ti = 0;
            for (int i = 0; i < OD; i++)
                if (c[i] > top) begin top = c[i]; ti = i; end
            ru = 0;
            for (int i = 0; i < OD; i++)
                if (i != ti && c[i] > ru) ru = c[i];
            e.iter   = IW'(k);
            e.winner = 4'(ti);
            if (k == limit) break;
            if (marg != 0 && top - ru >= marg) begin
                e.early = 1'b1;
                break;
            end
        end
        for (int i = 0; i < OD; i++) e.counts[i*CW +: CW] = CW'(c[i]);
        return e;
    endfunction

    task automatic run(input int limit, input int marg, input logic [OD-1:0] s0,
                       input logic [OD-1:0] s1, input int delay, input bit stall,
                       input bit poke_start);
        exp_t e;
        int cyc, wait_start, wcyc, k_iter;
        bit saw_low;
        sb.push_back(model(limit, marg, s0, s1, stall));
        start = 1'b1; iter_limit = IW'(limit); margin = CW'(marg);
        @(negedge clock);
        start = 1'b0;
        if (limit != 0) begin
            check("start_drops_finish", 64'(finish), 64'd0);
            check("start_clears_counts", 64'(counts), 64'd0);
            check("busy_after_start", 64'(busy), 64'd1);
        end
        cyc = 0; wait_start = -1; wcyc = 0; k_iter = 0; saw_low = 0;
        while (cyc < 2000 && !finish) begin
            if (!layer_reset) begin
                saw_low = 1;
                if (wait_start < 0) wait_start = cyc;
                layer_finish = 1'b0;
                if (poke_start && k_iter == 0 && wcyc == 0) begin
                    start = 1'b1; iter_limit = IW'(1);
                end
                if (!stall && wcyc == delay) begin
                    layer_finish = 1'b1;
                    sample = (k_iter % 2 == 0) ? s0 : s1;
                    k_iter++;
                end
                wcyc++;
            end else begin
                // Garbage outside WAIT must be ignored.
                wcyc = 0;
                layer_finish = 1'b1;
                sample = '1;
            end
            @(negedge clock);
            start = 1'b0;
            cyc++;
        end
        layer_finish = 1'b0;
        e = sb.pop_front();
        if (!finish) begin
            check("finish_within_budget", 64'(finish), 64'd1);
        end else begin
            check("counts", 64'(counts), 64'(e.counts));
            check("winner", 64'(winner), 64'(e.winner));
            check("iter_count", 64'(iter_count), 64'(e.iter));
            check("early_stop", 64'(early_stop), 64'(e.early));
            check("timeout", 64'(timeout), 64'(e.tmo));
            check("done_not_busy", 64'(busy), 64'd0);
            check("done_layer_reset", 64'(layer_reset), 64'd1);
            if (limit == 0) check("zero_limit_layer_reset_held", 64'(saw_low), 64'd0);
            if (stall) check("timeout_latency", 64'(cyc - wait_start), 64'(TOC));
            @(negedge clock);
            check("done_hold_finish", 64'(finish), 64'd1);
            check("done_hold_counts", 64'(counts), 64'(e.counts));
        end
        $display("run limit=%0d margin=%0d: iter=%0d winner=%0d early=%0d timeout=%0d counts=%h",
                 limit, marg, iter_count, winner, early_stop, timeout, counts);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; iter_limit = '0; margin = '0;
        layer_finish = 1'b0; sample = '0;
        repeat (2) @(negedge clock);
        check("rst_counts", 64'(counts), 64'd0);
        check("rst_winner", 64'(winner), 64'd0);
        check("rst_iter", 64'(iter_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_early", 64'(early_stop), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_layer_reset", 64'(layer_reset), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        run(5,   0, 10'b0000001000, 10'b0000001000, 1, 0, 0);
        run(100, 4, 10'b0000000010, 10'b0000000010, 0, 0, 0);
        run(2,   0, 10'b0000100100, 10'b0000100100, 3, 0, 0);
        run(10,  0, 10'b1111111111, 10'b1111111111, 0, 0, 0);
        run(3,   0, 10'b0000000000, 10'b0000000000, 0, 1, 0);
        run(0,   0, 10'b0000000001, 10'b0000000001, 0, 0, 0);
        run(20,  3, 10'b0000000011, 10'b0000000001, 1, 0, 1);

        // Reset during WAIT of the second iteration.
        start = 1'b1; iter_limit = IW'(5); margin = '0;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        begin
            int k_iter;
            k_iter = 0;
            while (cyc < 200 && reset == 1'b0) begin
                layer_finish = 1'b0;
                if (!layer_reset) begin
                    if (k_iter == 1) begin
                        reset = 1'b1;
                    end else begin
                        layer_finish = 1'b1; sample = 10'b0000010000; k_iter++;
                    end
                end
                @(negedge clock);
                cyc++;
            end
        end
        layer_finish = 1'b0;
        check("midrun_reset_reached", 64'(reset), 64'd1);
        check("midrun_counts", 64'(counts), 64'd0);
        check("midrun_finish", 64'(finish), 64'd0);
        check("midrun_busy", 64'(busy), 64'd0);
        check("midrun_layer_reset", 64'(layer_reset), 64'd1);
        check("midrun_iter", 64'(iter_count), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_stays_idle", 64'(busy), 64'd0);
        $display("reset mid-run: counts=%h finish=%0d layer_reset=%0d", counts, finish, layer_reset);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
